// File: rtl/bfp_dot_if.sv
// bfp_dot_if: operand stream, result stream and control for the BFP dot-product sequencer
interface bfp_dot_if #(
  parameter int SignFrac_size = 11,
  parameter int exp_size      = 5,
  parameter int ACC_W         = 32,
  parameter int CNT_W         = 8
);
  logic                       start;
  logic [CNT_W-1:0]           num_chunks;
  logic                       in_valid;
  logic                       in_ready;
  logic [4*SignFrac_size-1:0] a_vec;
  logic [4*SignFrac_size-1:0] b_vec;
  logic [exp_size-1:0]        a_exp;
  logic [exp_size-1:0]        b_exp;
  logic                       out_valid;
  logic                       out_ready;
  logic [ACC_W-1:0]           out_mant;
  logic [exp_size+1:0]        out_exp;
  logic                       busy;
  modport master (
    output start, num_chunks, in_valid, a_vec, b_vec, a_exp, b_exp, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, busy
  );
  modport slave (
    input  start, num_chunks, in_valid, a_vec, b_vec, a_exp, b_exp, out_ready,
    output in_ready, out_valid, out_mant, out_exp, busy
  );
endinterface

// File: rtl/bfp_dot_sequencer.sv
// bfp_dot_sequencer: runs the 4-lane adder tree over a chunked vector and accumulates one BFP result
module adder_tree #(
  parameter int SignFrac_size = 11
) (
  input  logic [4*SignFrac_size-1:0] i_a,
  input  logic [4*SignFrac_size-1:0] i_b,
  output logic [2*SignFrac_size+1:0] o_sum
);
  localparam int F  = SignFrac_size - 1;
  localparam int PW = 2*F + 4;
  localparam logic [SignFrac_size-1:0] MASK = {1'b0, {F{1'b1}}};
  logic [2*F-1:0] w_prod [4];
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign w_prod[i] = (i_a[i*SignFrac_size +: SignFrac_size] & MASK)
                     * (i_b[i*SignFrac_size +: SignFrac_size] & MASK);
  end
  assign o_sum = (PW'(w_prod[0]) + PW'(w_prod[1])) + (PW'(w_prod[2]) + PW'(w_prod[3]));
endmodule

module bfp_dot_sequencer #(
  parameter int SignFrac_size = 11,
  parameter int exp_size      = 5,
  parameter int ACC_W         = 32,
  parameter int CNT_W         = 8
) (
  input logic      clk,
  input logic      rst,
  bfp_dot_if.slave bus
);
  localparam int F  = SignFrac_size - 1;
  localparam int PW = 2*F + 4;
  localparam int EW = exp_size + 2;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [PW-1:0]    w_p, r_p;
  logic [EW-1:0]    w_e, r_e, r_acc_exp, w_base;
  logic [EW:0]      w_diff, w_sh;
  logic [ACC_W-1:0] r_acc, w_pa;
  logic [ACC_W:0]   w_sum;
  logic             r_v, r_first, w_hs, w_up, w_done, w_go;
  adder_tree #(.SignFrac_size(SignFrac_size)) u_tree (.i_a(bus.a_vec), .i_b(bus.b_vec), .o_sum(w_p));
  assign w_e    = {2'b0, bus.a_exp} + {2'b0, bus.b_exp} - EW'(2*F);
  assign w_hs   = bus.in_valid & (r_state == RUN);
  assign w_go   = (r_state == IDLE) & bus.start;
  assign w_done = r_state == DONE;
  // exponents are two's complement; compare via the sign of a one-bit-wider difference
  assign w_diff = {r_e[EW-1], r_e} - {r_acc_exp[EW-1], r_acc_exp};
  assign w_up   = ~w_diff[EW] & |w_diff;
  assign w_sh   = w_up ? w_diff : -w_diff;
  assign w_pa   = ACC_W'(r_p);
  assign w_sum  = r_first ? {1'b0, w_pa}
                : w_up    ? {1'b0, r_acc >> w_sh} + {1'b0, w_pa}
                :           {1'b0, r_acc} + {1'b0, w_pa >> w_sh};
  assign w_base = (r_first | w_up) ? r_e : r_acc_exp;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.start ? ((bus.num_chunks == '0) ? DONE : RUN) : IDLE;
      RUN:     w_next = (w_hs && r_cnt == CNT_W'(1)) ? DRAIN : RUN;
      DRAIN:   w_next = DONE;
      DONE:    w_next = bus.out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt     <= '0;
      r_p       <= '0;
      r_e       <= '0;
      r_v       <= 1'b0;
      r_first   <= 1'b0;
      r_acc     <= '0;
      r_acc_exp <= '0;
    end else begin
      r_v <= w_hs;
      if (w_hs) begin
        r_p   <= w_p;
        r_e   <= w_e;
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_go) begin
        r_cnt     <= bus.num_chunks;
        r_acc     <= '0;
        r_acc_exp <= '0;
        r_first   <= 1'b1;
      end else if (r_v) begin
        r_acc     <= w_sum[ACC_W] ? w_sum[ACC_W:1] : w_sum[ACC_W-1:0];
        r_acc_exp <= w_base + EW'(w_sum[ACC_W]);
        r_first   <= 1'b0;
      end
    end
  assign bus.in_ready  = r_state == RUN;
  assign bus.out_valid = w_done;
  assign bus.busy      = r_state != IDLE;
  assign bus.out_mant  = w_done ? r_acc : '0;
  assign bus.out_exp   = w_done ? r_acc_exp : '0;
endmodule

// File: tb/tb_bfp_dot_sequencer.sv
// tb_bfp_dot_sequencer: directed table plus randomized runs on 32- and 24-bit accumulator instances
module tb_bfp_dot_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  bfp_dot_if #(.ACC_W(32)) b32 ();
  bfp_dot_if #(.ACC_W(24)) b24 ();
  bfp_dot_sequencer #(.ACC_W(32)) d32 (.clk(clk), .rst(rst), .bus(b32));
  bfp_dot_sequencer #(.ACC_W(24)) d24 (.clk(clk), .rst(rst), .bus(b24));
  assign b24.start      = b32.start;
  assign b24.num_chunks = b32.num_chunks;
  assign b24.in_valid   = b32.in_valid;
  assign b24.a_vec      = b32.a_vec;
  assign b24.b_vec      = b32.b_vec;
  assign b24.a_exp      = b32.a_exp;
  assign b24.b_exp      = b32.b_exp;
  assign b24.out_ready  = b32.out_ready;

  typedef struct {
    int n;
    int va1, vb1, ae1, be1;
    int va2, vb2, ae2, be2;
    int hold;
    bit gaps;
    longint m32; int e32;
    longint m24; int e24;
  } vec_t;
  vec_t tbl [7];
  int ca [16][4];
  int cb [16][4];
  int cae [16];
  int cbe [16];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input longint act, input longint expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic chk_out(input string nm, input longint m32, input int e32, input longint m24, input int e24);
    chk({nm, ".mant32"}, longint'(b32.out_mant), m32);
    chk({nm, ".exp32"}, longint'(b32.out_exp), longint'(e32 & 127));
    chk({nm, ".mant24"}, longint'(b24.out_mant), m24);
    chk({nm, ".exp24"}, longint'(b24.out_exp), longint'(e24 & 127));
  endtask

  function automatic longint shr(input longint x, input int s, input int w);
    return (s >= w) ? 0 : (x >> s);
  endfunction

  // result follows the alignment/accumulation rules directly on integers
  function automatic void model(input int n, input int w, output longint m, output int e);
    longint p;
    int pe;
    m = 0;
    e = 0;
    for (int k = 0; k < n; k++) begin
      p = 0;
      for (int j = 0; j < 4; j++) p += longint'(ca[k][j] & 1023) * longint'(cb[k][j] & 1023);
      pe = cae[k] + cbe[k] - 20;
      if (k == 0) begin m = p; e = pe; end
      else if (pe > e) begin m = shr(m, pe - e, w) + p; e = pe; end
      else m = m + shr(p, e - pe, w);
      if (m >= (longint'(1) << w)) begin m = m >> 1; e++; end
    end
  endfunction

  task automatic drive_chunk(input int k);
    for (int j = 0; j < 4; j++) begin
      b32.a_vec[j*11 +: 11] = 11'(ca[k][j]);
      b32.b_vec[j*11 +: 11] = 11'(cb[k][j]);
    end
    b32.a_exp = 5'(cae[k]);
    b32.b_exp = 5'(cbe[k]);
  endtask

  task automatic fill(input vec_t v);
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 4; j++) begin
        ca[k][j] = (k == 0) ? v.va1 : v.va2;
        cb[k][j] = (k == 0) ? v.vb1 : v.vb2;
      end
      cae[k] = (k == 0) ? v.ae1 : v.ae2;
      cbe[k] = (k == 0) ? v.be1 : v.be2;
    end
  endtask

  // entered and left at a falling edge with the DUTs idle
  task automatic run(input int n, input int hold, input bit gaps,
                     input longint m32, input int e32, input longint m24, input int e24);
    int k = 0;
    int t = 0;
    bit hs;
    b32.start = 1'b1;
    b32.num_chunks = 8'(n);
    b32.in_valid = 1'b1;
    drive_chunk(0);
    chk("idle.in_ready", longint'(b32.in_ready), 0);
    @(negedge clk);
    b32.start = 1'b0;
    if (n == 0) begin
      chk("zero.out_valid", longint'(b32.out_valid), 1);
      chk("zero.in_ready", longint'(b32.in_ready), 0);
      @(negedge clk);
      b32.in_valid = 1'b0;
    end else begin
      while (k < n && t < 200) begin
        drive_chunk(k);
        b32.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        hs = b32.in_valid & b32.in_ready;
        @(negedge clk);
        if (hs) k++;
        t++;
      end
      b32.in_valid = 1'b0;
      chk("chunks.accepted", longint'(k), longint'(n));
      chk("drain.out_valid", longint'(b32.out_valid), 0);
      chk("drain.busy", longint'(b32.busy), 1);
      @(negedge clk);
      chk("done.out_valid", longint'(b32.out_valid), 1);
      chk("done.out_valid24", longint'(b24.out_valid), 1);
    end
    for (int h = 0; h < hold; h++) begin
      chk_out("hold", m32, e32, m24, e24);
      chk("hold.out_valid", longint'(b32.out_valid), 1);
      b32.start = (h == 0);
      @(negedge clk);
    end
    b32.start = 1'b0;
    chk_out("result", m32, e32, m24, e24);
    chk("result.busy", longint'(b32.busy), 1);
    b32.out_ready = 1'b1;
    @(negedge clk);
    b32.out_ready = 1'b0;
    chk("taken.out_valid", longint'(b32.out_valid), 0);
    chk("taken.busy", longint'(b32.busy), 0);
    chk("taken.out_mant", longint'(b32.out_mant), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    longint m32, m24;
    int e32, e24, n;
    tbl[0] = '{1, 1, 1, 10, 10, 1, 1, 10, 10, 0, 1'b0, 64'd4, 0, 64'd4, 0};
    tbl[1] = '{2, 1, 1, 10, 10, 2, 2, 11, 10, 10, 1'b0, 64'd18, 1, 64'd18, 1};
    tbl[2] = '{5, 1023, 1023, 10, 10, 1023, 1023, 10, 10, 0, 1'b0, 64'd20930580, 0, 64'd10465290, 1};
    tbl[3] = '{0, 1, 1, 10, 10, 1, 1, 10, 10, 2, 1'b0, 64'd0, 0, 64'd0, 0};
    tbl[4] = '{1, 'h7FF, 'h401, 10, 10, 1, 1, 10, 10, 0, 1'b1, 64'd4092, 0, 64'd4092, 0};
    tbl[5] = '{3, 2, 2, 15, 15, 1, 1, 10, 10, 0, 1'b0, 64'd16, 10, 64'd16, 10};
    tbl[6] = '{2, 1023, 1023, 10, 10, 1, 1, 31, 31, 1, 1'b0, 64'd4, 42, 64'd4, 42};
    b32.start = 1'b0;
    b32.num_chunks = '0;
    b32.in_valid = 1'b0;
    b32.a_vec = '0;
    b32.b_vec = '0;
    b32.a_exp = '0;
    b32.b_exp = '0;
    b32.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.out_valid", longint'(b32.out_valid), 0);
    chk("reset.busy", longint'(b32.busy), 0);
    chk("reset.in_ready", longint'(b32.in_ready), 0);
    chk_out("reset", 0, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      fill(tbl[i]);
      run(tbl[i].n, tbl[i].hold, tbl[i].gaps, tbl[i].m32, tbl[i].e32, tbl[i].m24, tbl[i].e24);
    end
    fill(tbl[2]);
    b32.start = 1'b1;
    b32.num_chunks = 8'd3;
    @(negedge clk);
    b32.start = 1'b0;
    b32.in_valid = 1'b1;
    drive_chunk(0);
    @(negedge clk);
    b32.in_valid = 1'b0;
    chk("midrun.busy", longint'(b32.busy), 1);
    rst = 1'b1;
    #1;
    chk("abort.busy", longint'(b32.busy), 0);
    chk("abort.in_ready", longint'(b32.in_ready), 0);
    chk("abort.out_valid", longint'(b32.out_valid), 0);
    chk_out("abort", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fill(tbl[0]);
    run(tbl[0].n, 0, 1'b0, tbl[0].m32, tbl[0].e32, tbl[0].m24, tbl[0].e24);
    for (int r = 0; r < 40; r++) begin
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) begin
        for (int j = 0; j < 4; j++) begin
          ca[k][j] = (r < 8) ? 1023 + 1024 * $urandom_range(0, 1) : $urandom_range(0, 2047);
          cb[k][j] = (r < 8) ? 1023 : $urandom_range(0, 2047);
        end
        cae[k] = $urandom_range(0, 31);
        cbe[k] = (r < 8) ? cae[0] : $urandom_range(0, 31);
        if (r < 8) cae[k] = 10;
      end
      model(n, 32, m32, e32);
      model(n, 24, m24, e24);
      run(n, $urandom_range(0, 3), 1'($urandom_range(0, 1)), m32, e32, m24, e24);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
